// File: rtl/program_loader_rom.sv
// Program RAM loaded byte-by-byte from a valid/ready port, served to the core by PC in run mode.
// Optional LOADER_CHECKSUM_EN builds an 8-bit running sum of accepted load bytes.
module program_loader_rom #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W:0]   prog_len,
  output logic              overflow,
  output logic              cpu_hold,
  output logic [DATA_W-1:0] checksum
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wp_q, wp_d;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                wr_en;
  logic                pc_in_prog;
  logic [DATA_W-1:0]   mem [DEPTH];

  // wp never exceeds DEPTH, so its top bit alone marks a full memory
  assign load_ready = (state_q == S_LOAD) && !wp_q[ADDR_W];
  assign cpu_hold   = (state_q != S_RUN);
  assign pc_in_prog = ({1'b0, pc} < prog_len_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wp_q          <= '0;
      prog_len_q    <= '0;
      overflow_q    <= 1'b0;
      instr_q       <= FILL;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      prog_len_q    <= prog_len_d;
      overflow_q    <= overflow_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    prog_len_d    = prog_len_q;
    overflow_d    = overflow_q;
    instr_d       = FILL;
    instr_valid_d = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_mode) begin
          state_d    = S_LOAD;
          wp_d       = '0;
          overflow_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (load_valid && load_ready) begin
          wr_en = 1'b1;
          wp_d  = wp_q + (ADDR_W+1)'(1);
        end else if (load_valid) begin
          overflow_d = 1'b1;
        end
        // a byte accepted in the exit cycle still counts toward the program length
        if (!load_mode) begin
          state_d    = S_RUN;
          prog_len_d = wp_d;
        end
      end
      S_RUN: begin
        instr_d       = pc_in_prog ? mem[pc] : FILL;
        instr_valid_d = pc_in_prog;
        if (load_mode) begin
          state_d    = S_LOAD;
          wp_d       = '0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // memory contents survive reset; a load interrupted by reset writes nothing that cycle
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wp_q[ADDR_W-1:0]] <= load_data;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              load_entry;

  assign load_entry = (state_q != S_LOAD) && load_mode;
  assign sum_d      = load_entry ? '0 : (wr_en ? sum_q + load_data : sum_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign prog_len    = prog_len_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_program_loader_rom.sv
// Bench for program_loader_rom: directed load/run scenarios checked against a behavioural model.
module tb_program_loader_rom;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_mode;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] pc;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [8:0] prog_len;
  logic       overflow;
  logic       cpu_hold;
  logic [7:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;

  program_loader_rom dut (
    .clk         (clk),
    .reset       (rst_n),
    .load_mode   (load_mode),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .pc          (pc),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .prog_len    (prog_len),
    .overflow    (overflow),
    .cpu_hold    (cpu_hold),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = loading, 2 = running
  int       m_mode = 0;
  int       m_wp = 0;
  int       m_len = 0;
  bit       m_ovf = 0;
  bit [7:0] m_sum = 0;
  bit [7:0] m_instr = 0;
  bit       m_iv = 0;
  bit [7:0] m_mem [256];
  bit       started = 0;

  always @(posedge clk) begin
    bit [7:0] n_instr;
    bit       n_iv;
    bit       ready;
    if (!rst_n) begin
      m_mode = 0; m_wp = 0; m_len = 0; m_ovf = 0; m_sum = 0; m_instr = 8'h00; m_iv = 0;
    end else begin
      ready   = (m_mode == 1) && (m_wp < 256);
      n_instr = 8'h00;
      n_iv    = 0;
      if (m_mode == 2 && int'(pc) < m_len) begin
        n_instr = m_mem[pc];
        n_iv    = 1;
      end
      if (m_mode == 0) begin
        if (load_mode) begin
          m_mode = 1; m_wp = 0; m_ovf = 0; m_sum = 0;
        end else begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (load_valid && ready) begin
          m_mem[m_wp] = load_data;
          m_wp++;
          m_sum = m_sum + load_data;
        end else if (load_valid) begin
          m_ovf = 1;
        end
        if (!load_mode) begin
          m_len  = m_wp;
          m_mode = 2;
        end
      end else begin
        if (load_mode) begin
          m_mode = 1; m_wp = 0; m_ovf = 0; m_sum = 0;
        end
      end
      m_instr = n_instr;
      m_iv    = n_iv;
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("instruction", 32'(instruction), 32'(m_instr));
      chk("instr_valid", 32'(instr_valid), 32'(m_iv));
      chk("prog_len", 32'(prog_len), 32'(m_len));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_mode != 2));
      chk("load_ready", 32'(load_ready), 32'((m_mode == 1) && (m_wp < 256)));
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(m_sum));
`else
      chk("checksum", 32'(checksum), 32'h0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load_byte(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] exp_i, input logic exp_v, input string tag);
    pc = a;
    cyc();
    chk({tag, "_instr"}, 32'(instruction), 32'(exp_i));
    chk({tag, "_valid"}, 32'(instr_valid), 32'(exp_v));
  endtask

  initial begin
    rst_n = 1'b0; load_mode = 1'b0; load_valid = 1'b0; load_data = 8'h00; pc = 8'h00;
    cyc(); cyc();
    chk("rst_instr", 32'(instruction), 32'h00);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'h1);
    chk("rst_len", 32'(prog_len), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h0);

    // basic load
    rst_n = 1'b1; load_mode = 1'b1;
    cyc();
    chk("enter_ready", 32'(load_ready), 32'h1);
    load_byte(8'h12); load_byte(8'h34); load_byte(8'h56);
    load_mode = 1'b0;
    cyc();
    chk("basic_len", 32'(prog_len), 32'd3);
    chk("basic_hold", 32'(cpu_hold), 32'h0);
`ifdef LOADER_CHECKSUM_EN
    chk("basic_sum", 32'(checksum), 32'h9C);
`endif
    fetch(8'd0, 8'h12, 1'b1, "b0");
    fetch(8'd1, 8'h34, 1'b1, "b1");
    fetch(8'd2, 8'h56, 1'b1, "b2");
    fetch(8'd3, 8'h00, 1'b0, "b3");

    // load_valid while running is ignored
    load_valid = 1'b1; load_data = 8'hEE;
    cyc();
    load_valid = 1'b0;
    chk("run_valid_ovf", 32'(overflow), 32'h0);

    // byte offered in the exit cycle
    load_mode = 1'b1;
    cyc();
    load_byte(8'hAA);
    load_valid = 1'b1; load_data = 8'hBB; load_mode = 1'b0;
    cyc();
    load_valid = 1'b0;
    chk("exit_len", 32'(prog_len), 32'd2);
    fetch(8'd1, 8'hBB, 1'b1, "exit1");
    fetch(8'd0, 8'hAA, 1'b1, "exit0");

    // full memory plus one extra byte
    load_mode = 1'b1;
    cyc();
    for (int i = 0; i < 256; i++) load_byte(8'(i * 3 + 1));
    chk("full_ready", 32'(load_ready), 32'h0);
    chk("full_ovf_pre", 32'(overflow), 32'h0);
    load_byte(8'hEE);
    chk("full_ovf", 32'(overflow), 32'h1);
    load_mode = 1'b0;
    cyc();
    chk("full_len", 32'(prog_len), 32'd256);
    fetch(8'hFF, 8'hFE, 1'b1, "full_ff");
    fetch(8'h00, 8'h01, 1'b1, "full_00");

    // reload: first a 3-byte program, then a 1-byte one
    load_mode = 1'b1;
    cyc();
    chk("reload_ovf_clr", 32'(overflow), 32'h0);
    load_byte(8'h12); load_byte(8'h34); load_byte(8'h56);
    load_mode = 1'b0;
    cyc();
    chk("reload_len3", 32'(prog_len), 32'd3);
    load_mode = 1'b1;
    cyc();
    chk("reload_hold", 32'(cpu_hold), 32'h1);
    chk("reload_len_kept", 32'(prog_len), 32'd3);
    load_byte(8'h77);
    load_mode = 1'b0;
    cyc();
    chk("reload_len1", 32'(prog_len), 32'd1);
    chk("reload_run", 32'(cpu_hold), 32'h0);
    fetch(8'd1, 8'h00, 1'b0, "reload1");
    fetch(8'd0, 8'h77, 1'b1, "reload0");

    // reset in the middle of a load
    load_mode = 1'b1;
    cyc();
    load_byte(8'h21); load_byte(8'h43);
    rst_n = 1'b0; load_mode = 1'b0;
    cyc();
    chk("mid_len", 32'(prog_len), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'h0);
    chk("mid_instr", 32'(instruction), 32'h00);
    chk("mid_hold", 32'(cpu_hold), 32'h1);
    rst_n = 1'b1;
    cyc();
    fetch(8'd0, 8'h00, 1'b0, "mid_pc0");
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
